// File: rtl/multimode_ring_counter_if.sv
// Bundles the control inputs and status outputs of multimode_ring_counter.
// The master side drives control and the slave side, the counter, returns status.
interface multimode_ring_counter_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned PW = $clog2(2 * WIDTH);

    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [PW-1:0]    phase;
    logic             tc;
    logic             legal;
    logic             err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, qbar, phase, tc, legal, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, qbar, phase, tc, legal, err
    );
endinterface

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with selectable direction, parallel load, a phase index,
// a terminal-count pulse and single-step recovery from illegal states.
module multimode_ring_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SEED_POS = 0
) (
    input logic                   clk,
    input logic                   rst,
    multimode_ring_counter_if.slave bus
);
    localparam int unsigned PW = $clog2(2 * WIDTH);

    localparam logic [WIDTH-1:0] RingSeed = WIDTH'(1) << SEED_POS;
    localparam logic [WIDTH-1:0] JohnSeed = '0;
    localparam logic [PW-1:0]    RingLast = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    JohnLast = PW'(2 * WIDTH - 1);

    // Which rule owns the next edge (reset is handled in the register process).
    typedef enum logic [2:0] {
        EvLoad,
        EvModeChange,
        EvCorrect,
        EvStep,
        EvHold
    } event_e;

    event_e           ev;
    logic [WIDTH-1:0] q_q, q_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             err_q, err_d;

    logic             legal;
    logic [PW-1:0]    phase_last;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] ring_up, ring_dn, john_up, john_dn;
    int unsigned      ones_cnt;
    int unsigned      edge_cnt;

    // Legality of the registered state under the registered mode.
    always_comb begin
        ones_cnt = 0;
        edge_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_q[i]) ones_cnt++;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q_q[i] != q_q[i+1]) edge_cnt++;
        end
        legal = mode_q ? (edge_cnt <= 1) : (ones_cnt == 1);
    end

    // Candidate next values for a normal step and the phase wrap point.
    always_comb begin
        ring_up    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ring_dn    = {q_q[0], q_q[WIDTH-1:1]};
        john_up    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        john_dn    = {~q_q[0], q_q[WIDTH-1:1]};
        phase_last = mode_q ? JohnLast : RingLast;
        unique case ({mode_q, bus.dir})
            2'b00:   step_val = ring_up;
            2'b01:   step_val = ring_dn;
            2'b10:   step_val = john_up;
            default: step_val = john_dn;
        endcase
    end

    // Priority decode of the non-reset events.
    always_comb begin
        ev = EvHold;
        if (bus.load) begin
            ev = EvLoad;
        end else if (bus.mode != mode_q) begin
            ev = EvModeChange;
        end else if (bus.en && !legal) begin
            ev = EvCorrect;
        end else if (bus.en) begin
            ev = EvStep;
        end
    end

    // Next-state values for the chosen event.
    always_comb begin
        q_d     = q_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        err_d   = 1'b0;
        unique case (ev)
            EvLoad: begin
                q_d     = bus.load_val;
                mode_d  = bus.mode;
                phase_d = '0;
            end
            EvModeChange: begin
                q_d     = bus.mode ? JohnSeed : RingSeed;
                mode_d  = bus.mode;
                phase_d = '0;
            end
            EvCorrect: begin
                q_d     = mode_q ? JohnSeed : RingSeed;
                phase_d = '0;
                err_d   = 1'b1;
            end
            EvStep: begin
                q_d     = step_val;
                phase_d = (phase_q == phase_last) ? '0 : phase_q + PW'(1);
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous active-low reset to the seed of the requested mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q     <= bus.mode ? JohnSeed : RingSeed;
            mode_q  <= bus.mode;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    // Outputs; tc only fires on a genuine step that wraps the phase.
    always_comb begin
        bus.q     = q_q;
        bus.qbar  = ~q_q;
        bus.phase = phase_q;
        bus.legal = legal;
        bus.err   = err_q;
        bus.tc    = rst && (ev == EvStep) && (phase_q == phase_last);
    end

    // A correction always restarts the phase.
    err_resets_phase: assert property (@(posedge clk) disable iff (!rst)
        err_q |-> (phase_q == '0));

endmodule

// File: doc/multimode_ring_counter.md
# multimode_ring_counter

Parametrised ring/Johnson (twisted-ring) counter with selectable shift direction, parallel load, and self-correction of illegal states. It generalises the fixed 4-bit ring counter to any width. It adds a phase index, a terminal-count pulse and an error flag, so downstream sequencers (phase generators, scan strobes, stepper drivers) can use it without external decode. Single clock domain, with one state register, one phase counter and one error flop.

## Interface
Parameters:
- WIDTH, 4, number of state bits; legal range ≥ 2.
- SEED_POS, 0, bit position of the single 1 in the ring-mode seed; range 0..WIDTH-1.
- PW, clog2(2*WIDTH), phase output width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low. rst=0 at a clk edge resets the block.
- en  input  1  advance one step this cycle.
- mode  input  1  0 = ring (period WIDTH), 1 = Johnson (period 2*WIDTH).
- dir  input  1  0 = up (bit i → bit i+1), 1 = down (bit i+1 → bit i).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded into q when load=1.
- q  output  WIDTH  counter state, registered.
- qbar  output  WIDTH  ~q, combinational.
- phase  output  PW  steps taken since the last seed or load, registered.
- tc  output  1  terminal count, combinational: en & (phase == period-1) & no higher-priority event.
- legal  output  1  combinational: q is a legal state for the current registered mode.
- err  output  1  registered one-cycle pulse. Set in the cycle after an illegal state was corrected.

## Operation
- Seeds:
  - Ring: one-hot with bit SEED_POS set.
  - Johnson: all zeros.
- Internal mode_q register tracks the mode that q currently follows.
- Per-edge priority, highest first:
  1. rst=0: q = seed(mode), mode_q = mode, phase = 0, err = 0.
  2. load=1: q = load_val, mode_q = mode, phase = 0, err = 0. en is ignored. The loaded value is not checked this cycle.
  3. mode != mode_q: q = seed(mode), mode_q = mode, phase = 0, err = 0. Takes effect regardless of en.
  4. en=1 and legal=0: q = seed(mode_q), phase = 0, err = 1.
  5. en=1 and legal=1, normal step:
     - Ring up: q = {q[W-2:0], q[W-1]}.
     - Ring down: q = {q[0], q[W-1:1]}.
     - Johnson up: q = {q[W-2:0], ~q[W-1]}.
     - Johnson down: q = {~q[0], q[W-1:1]}.
     - phase = (phase == period-1) ? 0 : phase+1.
     - err = 0.
  6. Otherwise hold q and phase; err = 0.
- Legality:
  - Ring: popcount(q) == 1.
  - Johnson: the number of indices i in 0..W-2 with q[i] != q[i+1] is ≤ 1. This admits exactly the 2*WIDTH Johnson states.
- dir may change on any cycle and takes effect on the next step. Phase keeps counting steps and does not reverse.
- tc asserts during the step that wraps phase to 0. An unbroken enabled sequence therefore produces one tc pulse per period.
- An illegal value is never held across an enabled step. Recovery takes at most one enabled cycle.

## Timing
- All state changes happen at the rising edge of clk. Reset has no asynchronous path.
- Latency:
  - load, mode change and correction are visible on q one cycle after the edge that samples them.
  - err is visible in the same cycle as the corrected q.
- With en held high, q advances one step per clk. With en low, q holds indefinitely.
- Mid-operation events:
  - Reset mid-sequence discards phase and any pending correction.
  - If rst=0, load=1 and en=1 arrive together, rst wins.
- qbar, legal and tc are combinational from the registers and inputs; none has a registered path.

## Test plan
- WIDTH=4, mode=0, dir=0, en=1 after reset → q = 0001, 0010, 0100, 1000, 0001. phase = 0,1,2,3,0. tc high only in the phase=3 cycle.
- mode=1, dir=0, en=1 after reset → q = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. tc at phase 7.
- Ring, dir=1 from seed 0001 → q = 1000, 0100, 0010, 0001. Then dir toggles to 0 mid-run at q=0100 → next q = 1000.
- load=1, load_val=0101, mode=0, then en=1 → q = 0101 with legal=0. Next edge: q = 0001, err = 1 for exactly one cycle, phase = 0.
- Johnson running at q=0111, mode switches to 0 with en=0 → next q = 0001, phase = 0, err = 0.
- Mid-sequence, rst=0 together with load=1 and en=1 → q = seed(mode), phase = 0, err = 0. load_val is ignored.
